vga_scan_timing: RTL and testbench

//  Scan-side timing generator for the 800x600@72Hz VGA output (50 MHz pixel clock).

---
 rtl/vga_timing_pkg.sv | 33 +++
 rtl/vga_delay_line.sv | 26 ++
 rtl/vga_scan_timing.sv | 135 +++++++++++++
 tb/tb_vga_scan_timing.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 800x600@72Hz scan timing constants, control-bit bundle and RGB565 expansion.
// The DEF_ prefix leaves the plain names free for the top-level parameters.
package vga_timing_pkg;

   localparam int CNT_W = 11;

   localparam int DEF_H_ACTIVE = 800;
   localparam int DEF_H_FP     = 56;
   localparam int DEF_H_SYNC   = 120;
   localparam int DEF_H_BP     = 64;
   localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;

   localparam int DEF_V_ACTIVE = 600;
   localparam int DEF_V_FP     = 37;
   localparam int DEF_V_SYNC   = 6;
   localparam int DEF_V_BP     = 23;
   localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

   localparam logic DEF_SYNC_POL   = 1'b1;
   localparam int   DEF_PIPE_DELAY = 2;

   typedef struct packed {
      logic hs;
      logic vs;
      logic active;
   } scan_ctl_t;

   // Replicate the top bits into the low bits so full-scale 565 maps to full-scale 888.
   function automatic logic [23:0] expand565(input logic [15:0] c);
      return {c[15:11], c[15:13], c[10:5], c[10:9], c[4:0], c[4:2]};
   endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Resettable fixed-depth shift register; realigns scan control bits with FIFO read data.
module vga_delay_line #(
   parameter int               WIDTH   = 3,
   parameter int               DEPTH   = 2,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] stage_q [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) stage_q[i] <= RST_VAL;
      end else begin
         stage_q[0] <= d_i;
         for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
   end

   assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_scan_timing.sv
// Scan counters, stage-0 sync/blank decode and the colour output register for the VGA DAC.
module vga_scan_timing
   import vga_timing_pkg::*;
#(
   parameter int   H_ACTIVE   = vga_timing_pkg::DEF_H_ACTIVE,
   parameter int   H_FP       = vga_timing_pkg::DEF_H_FP,
   parameter int   H_SYNC     = vga_timing_pkg::DEF_H_SYNC,
   parameter int   H_BP       = vga_timing_pkg::DEF_H_BP,
   parameter int   V_ACTIVE   = vga_timing_pkg::DEF_V_ACTIVE,
   parameter int   V_FP       = vga_timing_pkg::DEF_V_FP,
   parameter int   V_SYNC     = vga_timing_pkg::DEF_V_SYNC,
   parameter int   V_BP       = vga_timing_pkg::DEF_V_BP,
   parameter logic SYNC_POL   = vga_timing_pkg::DEF_SYNC_POL,
   parameter int   PIPE_DELAY = vga_timing_pkg::DEF_PIPE_DELAY
) (
   input  logic             scanClk,
   input  logic             resetn,
   input  logic [15:0]      cRGBin,
   output logic             activePixels,
   output logic             newFrame,
   output logic [CNT_W-1:0] pixelX,
   output logic [CNT_W-1:0] pixelY,
   output logic             VGA_HS,
   output logic             VGA_VS,
   output logic             VGA_BLANK_N,
   output logic             VGA_SYNC_N,
   output logic [7:0]       VGA_R,
   output logic [7:0]       VGA_G,
   output logic [7:0]       VGA_B
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] H_SS_C   = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] H_SE_C   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CNT_W-1:0] H_LAST_C = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] V_SS_C   = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] V_SE_C   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [CNT_W-1:0] V_LAST_C = CNT_W'(V_TOTAL - 1);

   localparam scan_ctl_t CTL_RST = '{hs: ~SYNC_POL, vs: ~SYNC_POL, active: 1'b0};

   logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
   logic [CNT_W-1:0] h_p0_q, v_p0_q;
   scan_ctl_t        ctl_p0_d, ctl_p0_q, ctl_dl;
   logic             nf_p0_d, nf_p0_q;
   logic             hs_q, vs_q, blank_n_q;
   logic [23:0]      rgb_d, rgb_q;

   always_comb begin
      h_d = h_q + 1'b1;
      v_d = v_q;
      if (h_q == H_LAST_C) begin
         h_d = '0;
         v_d = (v_q == V_LAST_C) ? '0 : v_q + 1'b1;
      end
   end

   always_ff @(posedge scanClk or negedge resetn) begin
      if (!resetn) begin
         h_q <= '0;
         v_q <= '0;
      end else begin
         h_q <= h_d;
         v_q <= v_d;
      end
   end

   // Stage 0: registered decode of the counters
   always_comb begin
      ctl_p0_d.active = (h_q < H_ACT_C) && (v_q < V_ACT_C);
      ctl_p0_d.hs     = ((h_q >= H_SS_C) && (h_q < H_SE_C)) ? SYNC_POL : ~SYNC_POL;
      ctl_p0_d.vs     = ((v_q >= V_SS_C) && (v_q < V_SE_C)) ? SYNC_POL : ~SYNC_POL;
      nf_p0_d         = (v_q >= V_ACT_C);
   end

   always_ff @(posedge scanClk or negedge resetn) begin
      if (!resetn) begin
         ctl_p0_q <= CTL_RST;
         nf_p0_q  <= 1'b0;
         h_p0_q   <= '0;
         v_p0_q   <= '0;
      end else begin
         ctl_p0_q <= ctl_p0_d;
         nf_p0_q  <= nf_p0_d;
         h_p0_q   <= h_q;
         v_p0_q   <= v_q;
      end
   end

   // Delay stages: cover the FIFO read latency
   vga_delay_line #(
      .WIDTH   ($bits(scan_ctl_t)),
      .DEPTH   (PIPE_DELAY),
      .RST_VAL (CTL_RST)
   ) u_ctl_delay (
      .clk   (scanClk),
      .rst_n (resetn),
      .d_i   (ctl_p0_q),
      .q_o   (ctl_dl)
   );

   // Output register: colour and its own sync/blank leave together
   always_comb begin
      rgb_d = ctl_dl.active ? expand565(cRGBin) : '0;
   end

   always_ff @(posedge scanClk or negedge resetn) begin
      if (!resetn) begin
         hs_q      <= ~SYNC_POL;
         vs_q      <= ~SYNC_POL;
         blank_n_q <= 1'b0;
         rgb_q     <= '0;
      end else begin
         hs_q      <= ctl_dl.hs;
         vs_q      <= ctl_dl.vs;
         blank_n_q <= ctl_dl.active;
         rgb_q     <= rgb_d;
      end
   end

   assign activePixels          = ctl_p0_q.active;
   assign newFrame              = nf_p0_q;
   assign pixelX                = h_p0_q;
   assign pixelY                = v_p0_q;
   assign VGA_HS                = hs_q;
   assign VGA_VS                = vs_q;
   assign VGA_BLANK_N           = blank_n_q;
   assign VGA_SYNC_N            = 1'b0;
   assign {VGA_R, VGA_G, VGA_B} = rgb_q;

endmodule

// File: tb/tb_vga_scan_timing.sv
// Bench: full 800x600 instance for line-level checks, a shrunken-timing instance for frame-level checks.
module tb_vga_scan_timing;

   logic clk = 1'b0;
   always #10 clk = ~clk;

   logic        rst_a, rst_b;
   logic [15:0] rgb_in_a, rgb_in_b;

   logic        a_act, a_nf, a_hs, a_vs, a_blank, a_sync;
   logic [10:0] a_px, a_py;
   logic [7:0]  a_r, a_g, a_b;
   logic        b_act, b_nf, b_hs, b_vs, b_blank, b_sync;
   logic [10:0] b_px, b_py;
   logic [7:0]  b_r, b_g, b_b;

   vga_scan_timing #(.PIPE_DELAY(2)) dut_a (
      .scanClk(clk), .resetn(rst_a), .cRGBin(rgb_in_a),
      .activePixels(a_act), .newFrame(a_nf), .pixelX(a_px), .pixelY(a_py),
      .VGA_HS(a_hs), .VGA_VS(a_vs), .VGA_BLANK_N(a_blank), .VGA_SYNC_N(a_sync),
      .VGA_R(a_r), .VGA_G(a_g), .VGA_B(a_b)
   );

   // Small frame: H 8/2/3/2 = 15 clocks, V 6/2/1/2 = 11 lines, 165 clocks per frame
   vga_scan_timing #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_ACTIVE(6), .V_FP(2), .V_SYNC(1), .V_BP(2),
      .SYNC_POL(1'b1), .PIPE_DELAY(2)
   ) dut_b (
      .scanClk(clk), .resetn(rst_b), .cRGBin(rgb_in_b),
      .activePixels(b_act), .newFrame(b_nf), .pixelX(b_px), .pixelY(b_py),
      .VGA_HS(b_hs), .VGA_VS(b_vs), .VGA_BLANK_N(b_blank), .VGA_SYNC_N(b_sync),
      .VGA_R(b_r), .VGA_G(b_g), .VGA_B(b_b)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [15:0] rgb565;
      logic [23:0] rgb888;
   } cvec_t;

   cvec_t vecs[6];

   initial begin
      bit   found;
      logic prev, prev2;
      int   nz, act_cnt, bl_cnt, nf_cnt, rise_n, rise0, rise1, rise_px, rise_py, hi_len;
      int   nf_rise_px, nf_rise_py, nf_fall_px, nf_fall_py, nf_rises, nf_falls, max_px, max_py;

      vecs[0] = '{16'hF800, 24'hFF0000};
      vecs[1] = '{16'h07E0, 24'h00FF00};
      vecs[2] = '{16'h001F, 24'h0000FF};
      vecs[3] = '{16'hFFFF, 24'hFFFFFF};
      vecs[4] = '{16'h8410, 24'h848284};
      vecs[5] = '{16'h1234, 24'h1045A5};

      rst_a = 1'b0; rst_b = 1'b0;
      rgb_in_a = 16'h0000; rgb_in_b = 16'hFFFF;
      repeat (10) tick();

      check("rst_hs", a_hs, 0);
      check("rst_vs", a_vs, 0);
      check("rst_blank_n", a_blank, 0);
      check("rst_rgb", {a_r, a_g, a_b}, 0);
      check("rst_active", a_act, 0);
      check("rst_newframe", a_nf, 0);
      check("rst_pixelx", a_px, 0);
      check("rst_sync_n", a_sync, 0);
      check("rst_b_rgb", {b_r, b_g, b_b}, 0);

      rst_a = 1'b1;
      tick();
      check("rel_px0", a_px, 0);
      check("rel_py0", a_py, 0);
      check("rel_active", a_act, 1);
      check("rel_blank_n_still0", a_blank, 0);
      tick();
      check("rel_px1", a_px, 1);
      tick();
      check("rel_px2", a_px, 2);

      // Start of line 1: colour and blank must appear PIPE_DELAY+1 clocks after activePixels
      rgb_in_a = 16'hF800;
      found = 0;
      prev  = a_act;
      for (int i = 0; i < 1200 && !found; i++) begin
         tick();
         if (!prev && a_act) found = 1;
         prev = a_act;
      end
      check("lat_found", found, 1);
      check("lat_px", a_px, 0);
      check("lat_py", a_py, 1);
      check("lat_blank_n_n0", a_blank, 0);
      tick(); tick();
      check("lat_blank_n_n2", a_blank, 0);
      check("lat_rgb_n2", {a_r, a_g, a_b}, 0);
      tick();
      check("lat_blank_n_n3", a_blank, 1);
      check("lat_rgb_n3", {a_r, a_g, a_b}, 24'hFF0000);

      for (int i = 0; i < 6; i++) begin
         rgb_in_a = vecs[i].rgb565;
         repeat (3) tick();
         check($sformatf("color%0d_rgb", i), {a_r, a_g, a_b}, vecs[i].rgb888);
         check($sformatf("color%0d_blank_n", i), a_blank, 1);
      end

      found = 0;
      for (int i = 0; i < 1100 && !found; i++) begin
         tick();
         if (a_px == 11'd810) found = 1;
      end
      check("blank_found", found, 1);
      rgb_in_a = 16'hFFFF;
      nz = 0;
      for (int i = 0; i < 200; i++) begin
         tick();
         if ({a_r, a_g, a_b} != 24'h0 || a_blank) nz++;
      end
      check("blank_nonzero_cycles", nz, 0);

      // Two full line periods inside the visible lines
      act_cnt = 0; bl_cnt = 0; rise_n = 0; rise0 = 0; rise1 = 0; rise_px = -1; hi_len = 0;
      prev = a_hs;
      for (int i = 0; i < 2080; i++) begin
         tick();
         if (a_act) act_cnt++;
         if (a_blank) bl_cnt++;
         if (a_hs && !prev) begin
            if (rise_n == 0) begin
               rise0 = i;
               rise_px = int'(a_px);
            end else if (rise_n == 1) begin
               rise1 = i;
            end
            rise_n++;
         end
         if (a_hs && rise_n == 1) hi_len++;
         prev = a_hs;
      end
      check("line_hs_rises", rise_n, 2);
      check("line_hs_period", rise1 - rise0, 1040);
      check("line_hs_width", hi_len, 120);
      // Stage-0 hs starts at pixelX 856; the output copy lags pixelX by PIPE_DELAY+1
      check("line_hs_rise_px", rise_px, 856 + 3);
      check("line_active_clks", act_cnt, 1600);
      check("line_blank_n_clks", bl_cnt, 1600);
      check("line_vs_idle", a_vs, 0);
      check("line_newframe_low", a_nf, 0);

      // Small-timing instance: frame-level behaviour
      rst_b = 1'b1;
      tick();
      check("b_rel_px", b_px, 0);
      check("b_rel_py", b_py, 0);
      check("b_rel_active", b_act, 1);

      act_cnt = 0; nf_cnt = 0; rise_n = 0; rise0 = 0; rise1 = 0; hi_len = 0;
      rise_px = -1; rise_py = -1; nf_rises = 0; nf_falls = 0;
      nf_rise_px = -1; nf_rise_py = -1; nf_fall_px = -1; nf_fall_py = -1; max_px = 0; max_py = 0;
      prev  = b_vs;
      prev2 = b_nf;
      for (int i = 0; i < 330; i++) begin
         tick();
         if (b_act) act_cnt++;
         if (b_nf) nf_cnt++;
         if (int'(b_px) > max_px) max_px = int'(b_px);
         if (int'(b_py) > max_py) max_py = int'(b_py);
         if (b_vs && !prev) begin
            if (rise_n == 0) begin
               rise0 = i; rise_px = int'(b_px); rise_py = int'(b_py);
            end else if (rise_n == 1) begin
               rise1 = i;
            end
            rise_n++;
         end
         if (b_vs && rise_n == 1) hi_len++;
         if (b_nf && !prev2 && nf_rises++ == 0) begin
            nf_rise_px = int'(b_px); nf_rise_py = int'(b_py);
         end
         if (!b_nf && prev2 && nf_falls++ == 0) begin
            nf_fall_px = int'(b_px); nf_fall_py = int'(b_py);
         end
         prev  = b_vs;
         prev2 = b_nf;
      end
      check("frm_vs_rises", rise_n, 2);
      check("frm_vs_period", rise1 - rise0, 165);
      check("frm_vs_width", hi_len, 15);
      check("frm_vs_rise_py", rise_py, 8);
      check("frm_vs_rise_px", rise_px, 3);
      check("frm_active_clks", act_cnt, 96);
      check("frm_newframe_clks", nf_cnt, 150);
      check("frm_nf_rise_py", nf_rise_py, 6);
      check("frm_nf_rise_px", nf_rise_px, 0);
      check("frm_nf_fall_py", nf_fall_py, 0);
      check("frm_nf_fall_px", nf_fall_px, 0);
      check("frm_max_px", max_px, 14);
      check("frm_max_py", max_py, 10);

      found = 0;
      for (int i = 0; i < 200 && !found; i++) begin
         tick();
         if (b_px == 11'd14 && b_py == 11'd10) found = 1;
      end
      check("wrap_found", found, 1);
      tick();
      check("wrap_px", b_px, 0);
      check("wrap_py", b_py, 0);
      check("wrap_newframe", b_nf, 0);
      check("wrap_active", b_act, 1);

      // Mid-frame reset with colour in flight
      found = 0;
      for (int i = 0; i < 200 && !found; i++) begin
         tick();
         if (b_px == 11'd4 && b_py == 11'd3) found = 1;
      end
      check("mid_found", found, 1);
      check("mid_pre_rgb", {b_r, b_g, b_b}, 24'hFFFFFF);
      rst_b = 1'b0;
      #1;
      check("mid_async_active", b_act, 0);
      check("mid_async_rgb", {b_r, b_g, b_b}, 0);
      check("mid_async_blank_n", b_blank, 0);
      check("mid_async_px", b_px, 0);
      check("mid_async_py", b_py, 0);
      repeat (3) tick();
      check("mid_hold_hs", b_hs, 0);
      check("mid_hold_vs", b_vs, 0);
      check("mid_hold_newframe", b_nf, 0);
      rst_b = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         tick();
         check($sformatf("mid_rel%0d_px", k), b_px, 11'(k - 1));
         check($sformatf("mid_rel%0d_py", k), b_py, 0);
         check($sformatf("mid_rel%0d_blank_n", k), b_blank, 0);
         check($sformatf("mid_rel%0d_rgb", k), {b_r, b_g, b_b}, 0);
      end
      tick();
      check("mid_rel4_blank_n", b_blank, 1);
      check("mid_rel4_rgb", {b_r, b_g, b_b}, 24'hFFFFFF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
